// File: rtl/pong_pkg.sv
// pong_pkg: game phase encoding, playfield/paddle geometry and serve position
// shared by the Pong game controller and its ball stepper.
package pong_pkg;
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } game_state_t;

    localparam logic [10:0] H_RES     = 11'd1024;
    localparam logic [10:0] V_RES     = 11'd768;
    localparam logic [10:0] BALL_SIZE = 11'd16;
    localparam logic [10:0] PAD_W     = 11'd16;
    localparam logic [10:0] PAD_H     = 11'd96;
    localparam logic [10:0] PAD_L_X   = 11'd32;
    localparam logic [10:0] PAD_R_X   = 11'd976;
    localparam logic [10:0] SPEED     = 11'd4;

    localparam logic [5:0] SERVE_DELAY = 6'd60;
    localparam logic [3:0] WIN_SCORE   = 4'd9;

    localparam logic [10:0] CENTRE_X = (H_RES - BALL_SIZE) / 2;
    localparam logic [10:0] CENTRE_Y = (V_RES - BALL_SIZE) / 2;
endpackage

// File: rtl/pong_ball_step.sv
// pong_ball_step: one frame of ball motion from the current position and
// directions, with wall/paddle reflection and goal-line miss detection.
module pong_ball_step
    import pong_pkg::*;
(
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic        dir_x,
    input  logic        dir_y,
    input  logic [10:0] pad_l_y,
    input  logic [10:0] pad_r_y,
    output logic [10:0] nx,
    output logic [10:0] ny,
    output logic        ndir_x,
    output logic        ndir_y,
    output logic        miss_l,
    output logic        miss_r
);
    logic ov_l, ov_r, wall_bot, wall_top, hit_l, hit_r;

    // dir_x=1 is rightward, dir_y=1 is downward; all bounds are tested before any subtraction
    always_comb begin
        ov_l     = (y + BALL_SIZE > pad_l_y) && (y < pad_l_y + PAD_H);
        ov_r     = (y + BALL_SIZE > pad_r_y) && (y < pad_r_y + PAD_H);
        wall_bot = dir_y && (y + SPEED >= V_RES - BALL_SIZE);
        wall_top = !dir_y && (y <= SPEED);
        ny       = wall_bot ? V_RES - BALL_SIZE : wall_top ? '0 : dir_y ? y + SPEED : y - SPEED;
        ndir_y   = wall_bot ? 1'b0 : wall_top ? 1'b1 : dir_y;
        hit_r    = dir_x && (x + BALL_SIZE <= PAD_R_X) && (x + BALL_SIZE + SPEED >= PAD_R_X) && ov_r;
        hit_l    = !dir_x && (x >= PAD_L_X + PAD_W) && (x <= PAD_L_X + PAD_W + SPEED) && ov_l;
        miss_r   = dir_x && !hit_r && (x + SPEED >= H_RES - BALL_SIZE);
        miss_l   = !dir_x && !hit_l && (x <= SPEED);
        nx       = hit_r ? PAD_R_X - BALL_SIZE : hit_l ? PAD_L_X + PAD_W :
                   (miss_r || miss_l) ? x : dir_x ? x + SPEED : x - SPEED;
        ndir_x   = hit_r ? 1'b0 : hit_l ? 1'b1 : miss_r ? 1'b1 : miss_l ? 1'b0 : dir_x;
    end
endmodule

// File: rtl/pong_game_ctl.sv
// pong_game_ctl: frame-synchronous Pong scheduler; one game update per frame at the
// rising edge of vertical blanking, publishing registered ball, score and phase.
module pong_game_ctl
    import pong_pkg::*;
(
    input  logic        pclk,
    input  logic        rst,
    input  logic        vblnk_in,
    input  logic        start,
    input  logic [10:0] pad_l_y,
    input  logic [10:0] pad_r_y,
    output logic [10:0] ball_x,
    output logic [10:0] ball_y,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic [2:0]  game_state,
    output logic        point_pulse
);
    game_state_t state, state_nxt;
    logic        vblnk_d, tick, win;
    logic        dir_x, dir_y, dir_x_nxt, dir_y_nxt, step_dx, step_dy, miss_l, miss_r, pulse_nxt;
    logic [5:0]  cnt, cnt_nxt;
    logic [10:0] x_nxt, y_nxt, step_x, step_y;
    logic [3:0]  sl_nxt, sr_nxt;

    assign tick       = vblnk_in & ~vblnk_d;
    assign win        = (score_l == WIN_SCORE) || (score_r == WIN_SCORE);
    assign game_state = state;

    pong_ball_step u_step (
        .x      (ball_x),
        .y      (ball_y),
        .dir_x  (dir_x),
        .dir_y  (dir_y),
        .pad_l_y(pad_l_y),
        .pad_r_y(pad_r_y),
        .nx     (step_x),
        .ny     (step_y),
        .ndir_x (step_dx),
        .ndir_y (step_dy),
        .miss_l (miss_l),
        .miss_r (miss_r)
    );

    always_ff @(posedge pclk) begin
        if (rst) begin
            state       <= ST_IDLE;
            vblnk_d     <= 1'b0;
            ball_x      <= CENTRE_X;
            ball_y      <= CENTRE_Y;
            dir_x       <= 1'b1;
            dir_y       <= 1'b1;
            score_l     <= '0;
            score_r     <= '0;
            cnt         <= '0;
            point_pulse <= 1'b0;
        end else begin
            state       <= state_nxt;
            vblnk_d     <= vblnk_in;
            ball_x      <= x_nxt;
            ball_y      <= y_nxt;
            dir_x       <= dir_x_nxt;
            dir_y       <= dir_y_nxt;
            score_l     <= sl_nxt;
            score_r     <= sr_nxt;
            cnt         <= cnt_nxt;
            point_pulse <= pulse_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (tick)
            case (state)
                ST_IDLE:  state_nxt = start ? ST_SERVE : ST_IDLE;
                ST_SERVE: state_nxt = (cnt == SERVE_DELAY - 6'd1) ? ST_PLAY : ST_SERVE;
                ST_PLAY:  state_nxt = (miss_l || miss_r) ? ST_POINT : ST_PLAY;
                ST_POINT: state_nxt = win ? ST_OVER : ST_SERVE;
                ST_OVER:  state_nxt = start ? ST_SERVE : ST_OVER;
                default:  state_nxt = ST_IDLE;
            endcase
    end

    // a miss freezes x and turns the ball toward the player who conceded
    always_comb begin
        x_nxt     = ball_x;
        y_nxt     = ball_y;
        dir_x_nxt = dir_x;
        dir_y_nxt = dir_y;
        sl_nxt    = score_l;
        sr_nxt    = score_r;
        cnt_nxt   = cnt;
        pulse_nxt = 1'b0;
        if (tick)
            case (state)
                ST_IDLE:  cnt_nxt = '0;
                ST_SERVE: cnt_nxt = (cnt == SERVE_DELAY - 6'd1) ? '0 : cnt + 6'd1;
                ST_PLAY: begin
                    x_nxt     = step_x;
                    y_nxt     = step_y;
                    dir_x_nxt = step_dx;
                    dir_y_nxt = step_dy;
                    sl_nxt    = (miss_r && score_l != WIN_SCORE) ? score_l + 4'd1 : score_l;
                    sr_nxt    = (miss_l && score_r != WIN_SCORE) ? score_r + 4'd1 : score_r;
                    pulse_nxt = miss_l | miss_r;
                end
                ST_POINT: if (!win) begin
                    x_nxt   = CENTRE_X;
                    y_nxt   = CENTRE_Y;
                    cnt_nxt = '0;
                end
                ST_OVER: if (start) begin
                    x_nxt     = CENTRE_X;
                    y_nxt     = CENTRE_Y;
                    dir_x_nxt = 1'b1;
                    sl_nxt    = '0;
                    sr_nxt    = '0;
                    cnt_nxt   = '0;
                end
                default: ;
            endcase
    end
endmodule

// File: tb/tb_pong_game_ctl.sv
// tb_pong_game_ctl: randomized frames and paddles checked every cycle against a
// frame-level integer model of the game rules.
module tb_pong_game_ctl;
    logic        pclk = 1'b0;
    logic        rst, vblnk_in, start;
    logic [10:0] pad_l_y, pad_r_y;
    logic [10:0] ball_x, ball_y;
    logic [3:0]  score_l, score_r;
    logic [2:0]  game_state;
    logic        point_pulse;

    int n_checks = 0, n_fail = 0;
    int m_x, m_y, m_vx, m_vy, m_sl, m_sr, m_st, m_serve, m_pulse, m_vd;
    bit track_l, track_r, did_rst;

    pong_game_ctl dut (
        .pclk       (pclk),
        .rst        (rst),
        .vblnk_in   (vblnk_in),
        .start      (start),
        .pad_l_y    (pad_l_y),
        .pad_r_y    (pad_r_y),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .score_l    (score_l),
        .score_r    (score_r),
        .game_state (game_state),
        .point_pulse(point_pulse)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        n_checks++;
        if (obs !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic centre();
        m_x = 504;
        m_y = 376;
    endtask

    // state numbering: 0 idle, 1 serve, 2 play, 3 point, 4 over; velocities are +1/-1 per axis
    task automatic model_step(input bit v, input bit s, input bit r);
        int ny, pl, pr;
        bit ov_l, ov_r, tk;
        if (r) begin
            centre();
            m_vx = 1; m_vy = 1; m_sl = 0; m_sr = 0; m_st = 0; m_serve = 0; m_pulse = 0; m_vd = 0;
            return;
        end
        tk = v && !m_vd;
        m_vd = v;
        m_pulse = 0;
        if (!tk) return;
        pl = int'(pad_l_y);
        pr = int'(pad_r_y);
        case (m_st)
            0: if (s) begin m_st = 1; m_serve = 0; end
            1: begin
                m_serve++;
                if (m_serve == 60) m_st = 2;
            end
            2: begin
                ov_l = (m_y + 16 > pl) && (m_y < pl + 96);
                ov_r = (m_y + 16 > pr) && (m_y < pr + 96);
                ny = m_y + 4 * m_vy;
                if (ny >= 752) begin ny = 752; m_vy = -1; end
                else if (ny <= 0) begin ny = 0; m_vy = 1; end
                if (m_vx > 0) begin
                    if (m_x + 16 <= 976 && m_x + 20 >= 976 && ov_r) begin m_x = 960; m_vx = -1; end
                    else if (m_x + 4 >= 1008) begin
                        if (m_sl < 9) m_sl++;
                        m_st = 3; m_pulse = 1; m_vx = 1;
                    end else m_x += 4;
                end else begin
                    if (m_x >= 48 && m_x - 4 <= 48 && ov_l) begin m_x = 48; m_vx = 1; end
                    else if (m_x - 4 <= 0) begin
                        if (m_sr < 9) m_sr++;
                        m_st = 3; m_pulse = 1; m_vx = -1;
                    end else m_x -= 4;
                end
                m_y = ny;
            end
            3: if (m_sl == 9 || m_sr == 9) m_st = 4;
               else begin m_st = 1; m_serve = 0; centre(); end
            4: if (s) begin m_st = 1; m_serve = 0; m_sl = 0; m_sr = 0; m_vx = 1; centre(); end
            default: ;
        endcase
    endtask

    function automatic logic [10:0] pick_pad(input bit track);
        int t;
        if (!track) return 11'($urandom_range(0, 672));
        t = m_y + 8 - 48;
        t = (t < 0) ? 0 : (t > 672) ? 672 : t;
        return 11'(t);
    endfunction

    task automatic cyc(input bit v, input bit s, input bit r);
        @(negedge pclk);
        vblnk_in = v;
        start    = s;
        rst      = r;
        pad_l_y  = pick_pad(track_l);
        pad_r_y  = pick_pad(track_r);
        model_step(v, s, r);
        @(posedge pclk);
        #1;
        check("ball_x", 32'(ball_x), m_x);
        check("ball_y", 32'(ball_y), m_y);
        check("score_l", 32'(score_l), m_sl);
        check("score_r", 32'(score_r), m_sr);
        check("game_state", 32'(game_state), m_st);
        check("point_pulse", 32'(point_pulse), m_pulse);
    endtask

    task automatic frame(input bit s_en);
        int len;
        len = $urandom_range(5, 8);
        track_l = ($urandom_range(0, 3) == 0);
        track_r = ($urandom_range(0, 3) == 0);
        for (int i = 0; i < len; i++)
            cyc(i < 3, s_en && ($urandom_range(0, 7) == 0), 1'b0);
    endtask

    initial begin
        rst = 1'b1; vblnk_in = 1'b0; start = 1'b0; pad_l_y = '0; pad_r_y = '0;
        did_rst = 1'b0;
        model_step(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        for (int f = 0; f < 3; f++) frame(1'b0);
        for (int f = 0; f < 6000; f++) begin
            if (f >= 3000 && !did_rst && m_st == 2) begin
                cyc(1'b0, 1'b0, 1'b1);
                did_rst = 1'b1;
            end
            frame(1'b1);
        end
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
